instr_mem_dp: RTL and testbench

Parametrised dual-port instruction memory, the successor to the single-port synchronous instruction memory. It has an independent fetch read port and a streaming loader write port, so the core can fetch while a program image is loaded. A loader FSM with a valid/ready handshake writes beats to auto-incrementing addresses from a programmable base. The block sits between the program loader (host/testbench side) and the fetch stage of the core.

---
 rtl/instr_mem_dp.sv | 133 +++++++++++++
 tb/tb_instr_mem_dp.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_dp.sv
// Dual-port instruction memory: registered fetch port plus a
// streaming loader that writes bursts to auto-incrementing addresses.
module instr_mem_dp #(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_en_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic [data_width_p-1:0] rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    load_start_i,
  input  logic [addr_width_p-1:0] load_base_i,
  input  logic [addr_width_p:0]   load_count_i,
  input  logic                    load_valid_i,
  input  logic [data_width_p-1:0] load_data_i,
  output logic                    load_ready_o,
  output logic                    load_busy_o,
  output logic                    load_done_o
);

  localparam int depth_lp = 2 ** addr_width_p;

  localparam logic [addr_width_p:0] depth_cnt_lp =
    {1'b1, {addr_width_p{1'b0}}};

  localparam logic [addr_width_p:0] one_cnt_lp =
    {{addr_width_p{1'b0}}, 1'b1};

  localparam logic [addr_width_p:0] zero_cnt_lp = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [addr_width_p-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width_p:0]   rem_q, rem_d;
  logic [addr_width_p:0]   cnt_sat;
  logic                    accept;
  logic                    bypass;

  logic [data_width_p-1:0] mem [depth_lp];

  // A burst longer than the array would only overwrite itself.
  always_comb begin
    cnt_sat = load_count_i;
    if (load_count_i > depth_cnt_lp)
      cnt_sat = depth_cnt_lp;
  end

  assign accept = (state_q == LOAD) & load_valid_i;

  assign bypass = accept & (rd_addr_i == wr_ptr_q);

  // Handshake outputs depend on state alone.
  assign load_ready_o = (state_q == LOAD);
  assign load_busy_o  = (state_q != IDLE);
  assign load_done_o  = (state_q == DONE);

  // Loader next-state, pointer and beat counter.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rem_d    = rem_q;
    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          wr_ptr_d = load_base_i;
          rem_d    = cnt_sat;
          if (load_count_i == zero_cnt_lp)
            state_d = DONE;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_valid_i) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rem_d    = rem_q - one_cnt_lp;
          if (rem_q == one_cnt_lp)
            state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Loader state register; reset abandons any burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rem_q    <= rem_d;
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr_q] <= load_data_i;
  end

  // Fetch port with write-first bypass on a same-cycle hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        if (bypass)
          rd_data_o <= load_data_i;
        else
          rd_data_o <= mem[rd_addr_i];
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_dp.sv
// Directed bench for instr_mem_dp with a read-data scoreboard.
// Covers load/readback, wrap, stall, bypass, zero count and reset.
module tb_instr_mem_dp;

  logic clk = 1'b0;
  logic reset;

  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        start;
  logic [9:0]  base;
  logic [10:0] count;
  logic        valid;
  logic [31:0] data;
  logic        ready, busy, done;

  logic        rd_en4;
  logic [3:0]  rd_addr4;
  logic [31:0] rd_data4;
  logic        rd_valid4;
  logic        start4;
  logic [3:0]  base4;
  logic [4:0]  count4;
  logic        valid4;
  logic [31:0] data4;
  logic        ready4, busy4, done4;

  logic [31:0] q[$];
  logic [31:0] q4[$];
  logic [31:0] e0, e4;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  instr_mem_dp dut (
    .clk(clk), .reset(reset),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .load_start_i(start), .load_base_i(base),
    .load_count_i(count), .load_valid_i(valid),
    .load_data_i(data), .load_ready_o(ready),
    .load_busy_o(busy), .load_done_o(done)
  );

  instr_mem_dp #(.addr_width_p(4), .data_width_p(32)) dut4 (
    .clk(clk), .reset(reset),
    .rd_en_i(rd_en4), .rd_addr_i(rd_addr4),
    .rd_data_o(rd_data4), .rd_valid_o(rd_valid4),
    .load_start_i(start4), .load_base_i(base4),
    .load_count_i(count4), .load_valid_i(valid4),
    .load_data_i(data4), .load_ready_o(ready4),
    .load_busy_o(busy4), .load_done_o(done4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every valid read pops the oldest expectation.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_valid) begin
      chk("rd_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        e0 = q.pop_front();
        chk("rd_data", rd_data, e0);
      end
    end
    if (rd_valid4) begin
      chk("rd4_pending", q4.size() != 0, 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("rd4_data", rd_data4, e4);
      end
    end
  end

  task automatic rd(input logic [9:0] a, input logic [31:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rd4(input logic [3:0] a, input logic [31:0] e);
    rd_en4   = 1'b1;
    rd_addr4 = a;
    q4.push_back(e);
    tick();
    rd_en4 = 1'b0;
  endtask

  task automatic load_burst(input logic [9:0]  b,
                            input logic [10:0] n,
                            input logic [31:0] d0);
    start = 1'b1;
    base  = b;
    count = n;
    tick();
    start = 1'b0;
    chk("lb_ready", ready, 1);
    for (int i = 0; i < int'(n); i++) begin
      valid = 1'b1;
      data  = d0 + i;
      tick();
      if (i < int'(n) - 1) chk("lb_done_early", done, 0);
    end
    valid = 1'b0;
    chk("lb_done", done, 1);
    tick();
    chk("lb_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    rd_en = 0; rd_addr = 0; start = 0; base = 0;
    count = 0; valid = 0; data = 0;
    rd_en4 = 0; rd_addr4 = 0; start4 = 0; base4 = 0;
    count4 = 0; valid4 = 0; data4 = 0;
    tick();
    tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst4_busy", busy4, 0);
    reset = 1'b0;
    tick();

    load_burst(10'h100, 11'd1, 32'h0BEE);

    // basic load with an ignored mid-burst start
    snap  = done_cnt;
    start = 1'b1;
    base  = 10'h010;
    count = 11'd4;
    tick();
    start = 1'b0;
    chk("t1_ready", ready, 1);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = 32'hA0 + i;
      if (i == 1) begin
        start = 1'b1;
        base  = 10'h100;
        count = 11'd1;
      end
      tick();
      start = 1'b0;
      if (i < 3) chk("t1_done_early", done, 0);
      if (i < 3) chk("t1_ready_mid", ready, 1);
    end
    valid = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_ready_done", ready, 0);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_done_once", done_cnt - snap, 1);

    for (int i = 0; i < 4; i++)
      rd(10'h010 + 10'(i), 32'hA0 + i);
    rd(10'h100, 32'h0BEE);
    tick();

    // read hold
    rd(10'h010, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", rd_data, 32'hA0);
      chk("hold_valid", rd_valid, 0);
    end

    // bypass during load
    start = 1'b1;
    base  = 10'h020;
    count = 11'd2;
    tick();
    start   = 1'b0;
    valid   = 1'b1;
    data    = 32'h55;
    rd_en   = 1'b1;
    rd_addr = 10'h020;
    q.push_back(32'h55);
    tick();
    rd_en = 1'b0;
    chk("byp_valid", rd_valid, 1);
    data = 32'h56;
    tick();
    valid = 1'b0;
    chk("byp_done", done, 1);
    tick();
    rd(10'h020, 32'h55);
    rd(10'h021, 32'h56);
    tick();

    // zero count
    start = 1'b1;
    base  = 10'h010;
    count = 11'd0;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    chk("z_ready", ready, 0);
    tick();
    chk("z_done_off", done, 0);
    chk("z_idle", busy, 0);
    rd(10'h010, 32'hA0);
    tick();

    // reset mid-burst
    snap  = done_cnt;
    start = 1'b1;
    base  = 10'h040;
    count = 11'd8;
    tick();
    start = 1'b0;
    valid = 1'b1;
    data  = 32'h70;
    tick();
    data = 32'h71;
    tick();
    data = 32'h72;
    #2 reset = 1'b1;
    #1;
    chk("mr_ready", ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_rd_valid", rd_valid, 0);
    valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("mr_no_done", done_cnt - snap, 0);
    chk("mr_idle", busy, 0);
    rd(10'h040, 32'h70);
    rd(10'h041, 32'h71);
    tick();
    load_burst(10'h040, 11'd3, 32'h90);
    rd(10'h040, 32'h90);
    rd(10'h042, 32'h92);
    tick();

    // wrap and stall on the narrow instance
    start4 = 1'b1;
    base4  = 4'hE;
    count4 = 5'd4;
    tick();
    start4 = 1'b0;
    valid4 = 1'b1;
    data4  = 32'hC0;
    tick();
    data4 = 32'hC1;
    tick();
    valid4 = 1'b0;
    data4  = 32'hEE;
    tick();
    tick();
    chk("w_stall_busy", busy4, 1);
    chk("w_stall_ready", ready4, 1);
    valid4 = 1'b1;
    data4  = 32'hC2;
    tick();
    data4 = 32'hC3;
    tick();
    valid4 = 1'b0;
    chk("w_done", done4, 1);
    tick();
    rd4(4'hE, 32'hC0);
    rd4(4'hF, 32'hC1);
    rd4(4'h0, 32'hC2);
    rd4(4'h1, 32'hC3);
    tick();

    // oversize count saturates to depth
    start4 = 1'b1;
    base4  = 4'h3;
    count4 = 5'd20;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid4 = 1'b1;
      data4  = 32'hD0 + i;
      tick();
      if (i < 15) chk("s_done_early", done4, 0);
    end
    valid4 = 1'b0;
    chk("s_done", done4, 1);
    tick();
    chk("s_idle", busy4, 0);
    rd4(4'h3, 32'hD0);
    rd4(4'h2, 32'hDF);
    tick();
    tick();

    chk("q_drained", q.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
